// File: rtl/julia_frame_scheduler.sv
// Frame sequencer for a Julia-set renderer: walks the raster, hands each pixel's initial z
// to the lowest free escape core, and streams tagged iteration counts back out.
module julia_frame_scheduler #(
  parameter int N_CORES         = 4,
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int COORD_WIDTH     = 11
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              frame_start_i,
  input  logic [COORD_WIDTH-1:0]            width_i,
  input  logic [COORD_WIDTH-1:0]            height_i,
  input  logic [DATA_WIDTH-1:0]             x0_i,
  input  logic [DATA_WIDTH-1:0]             y0_i,
  input  logic [DATA_WIDTH-1:0]             dx_i,
  input  logic [DATA_WIDTH-1:0]             dy_i,
  input  logic [DATA_WIDTH-1:0]             cx_i,
  input  logic [DATA_WIDTH-1:0]             cy_i,
  input  logic [MAX_ITER_WIDTH-1:0]         max_iter_i,
  output logic                              busy_o,
  output logic                              frame_done_o,
  output logic [N_CORES-1:0]                core_start_o,
  output logic [DATA_WIDTH-1:0]             core_zx_o,
  output logic [DATA_WIDTH-1:0]             core_zy_o,
  output logic [DATA_WIDTH-1:0]             core_cx_o,
  output logic [DATA_WIDTH-1:0]             core_cy_o,
  output logic [MAX_ITER_WIDTH-1:0]         core_max_iter_o,
  input  logic [N_CORES-1:0]                core_done_i,
  input  logic [N_CORES*MAX_ITER_WIDTH-1:0] core_iter_i,
  output logic                              pix_valid_o,
  input  logic                              pix_ready_i,
  output logic [COORD_WIDTH-1:0]            pix_x_o,
  output logic [COORD_WIDTH-1:0]            pix_y_o,
  output logic [MAX_ITER_WIDTH-1:0]         pix_iter_o,
  output logic [1:0]                        dbg_state_o
);
  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                r_state;
  logic [COORD_WIDTH-1:0]    r_width, r_height, r_px, r_py;
  logic [DATA_WIDTH-1:0]     r_x0, r_dx, r_dy, r_zx, r_zy;
  logic [N_CORES-1:0]        r_core_busy, r_core_done;
  logic [COORD_WIDTH-1:0]    r_tag_x [N_CORES];
  logic [COORD_WIDTH-1:0]    r_tag_y [N_CORES];

  logic [N_CORES-1:0]        w_free, w_complete, w_disp_oh, w_coll_oh;
  logic                      w_have_free, w_have_done, w_dispatch, w_collect, w_out_take;
  logic                      w_empty_frame, w_last_col, w_last_pix, w_all_idle;
  logic [IDX_W-1:0]          w_free_idx, w_done_idx;
  logic [COORD_WIDTH-1:0]    w_done_x, w_done_y;
  logic [MAX_ITER_WIDTH-1:0] w_done_iter;

  // The done level is stale during the start cycle, so it only counts from the next cycle on.
  assign w_free     = ~(r_core_busy | r_core_done);
  assign w_complete = r_core_busy & core_done_i & ~core_start_o;

  always_comb begin
    w_have_free = 1'b0;
    w_free_idx  = '0;
    w_have_done = 1'b0;
    w_done_idx  = '0;
    w_done_x    = '0;
    w_done_y    = '0;
    w_done_iter = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (w_free[k]) begin
        w_have_free = 1'b1;
        w_free_idx  = IDX_W'(k);
      end
      if (r_core_done[k]) begin
        w_have_done = 1'b1;
        w_done_idx  = IDX_W'(k);
        w_done_x    = r_tag_x[k];
        w_done_y    = r_tag_y[k];
        w_done_iter = core_iter_i[k*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
      end
    end
  end

  assign w_empty_frame = (r_width == '0) || (r_height == '0);
  assign w_last_col    = (r_px == r_width - 1'b1);
  assign w_last_pix    = w_last_col && (r_py == r_height - 1'b1);
  assign w_dispatch    = (r_state == S_RUN) && !w_empty_frame && w_have_free;
  assign w_out_take    = !pix_valid_o || pix_ready_i;
  assign w_collect     = w_out_take && w_have_done;
  assign w_disp_oh     = w_dispatch ? (N_CORES'(1) << w_free_idx) : '0;
  assign w_coll_oh     = w_collect ? (N_CORES'(1) << w_done_idx) : '0;
  assign w_all_idle    = (r_core_busy == '0) && (r_core_done == '0) && !pix_valid_o;

  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_width         <= '0;
      r_height        <= '0;
      r_px            <= '0;
      r_py            <= '0;
      r_x0            <= '0;
      r_dx            <= '0;
      r_dy            <= '0;
      r_zx            <= '0;
      r_zy            <= '0;
      core_cx_o       <= '0;
      core_cy_o       <= '0;
      core_max_iter_o <= '0;
      frame_done_o    <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (r_state)
        S_IDLE: if (frame_start_i) begin
          r_width         <= width_i;
          r_height        <= height_i;
          r_x0            <= x0_i;
          r_dx            <= dx_i;
          r_dy            <= dy_i;
          r_zx            <= x0_i;
          r_zy            <= y0_i;
          r_px            <= '0;
          r_py            <= '0;
          core_cx_o       <= cx_i;
          core_cy_o       <= cy_i;
          core_max_iter_o <= max_iter_i;
          r_state         <= S_RUN;
        end
        S_RUN: begin
          if (w_empty_frame) begin
            r_state <= S_DRAIN;
          end else if (w_dispatch) begin
            if (w_last_col) begin
              r_px <= '0;
              r_zx <= r_x0;
              r_py <= r_py + 1'b1;
              r_zy <= r_zy + r_dy;
            end else begin
              r_px <= r_px + 1'b1;
              r_zx <= r_zx + r_dx;
            end
            if (w_last_pix) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (w_all_idle) begin
          frame_done_o <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-core FREE/BUSY/DONE tracking; a core leaves DONE only when its result is loaded out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_core_busy  <= '0;
      r_core_done  <= '0;
      core_start_o <= '0;
      core_zx_o    <= '0;
      core_zy_o    <= '0;
      for (int k = 0; k < N_CORES; k++) begin
        r_tag_x[k] <= '0;
        r_tag_y[k] <= '0;
      end
    end else begin
      r_core_busy  <= (r_core_busy & ~w_complete) | w_disp_oh;
      r_core_done  <= (r_core_done | w_complete) & ~w_coll_oh;
      core_start_o <= w_disp_oh;
      if (w_dispatch) begin
        core_zx_o <= r_zx;
        core_zy_o <= r_zy;
      end
      for (int k = 0; k < N_CORES; k++) begin
        if (w_disp_oh[k]) begin
          r_tag_x[k] <= r_px;
          r_tag_y[k] <= r_py;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_valid_o <= 1'b0;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      pix_iter_o  <= '0;
    end else if (w_out_take) begin
      pix_valid_o <= w_have_done;
      if (w_have_done) begin
        pix_x_o    <= w_done_x;
        pix_y_o    <= w_done_y;
        pix_iter_o <= w_done_iter;
      end
    end
  end
endmodule

// File: tb/tb_julia_frame_scheduler.sv
// Bench for julia_frame_scheduler: behavioural escape cores with per-core latency,
// an output monitor feeding a coordinate-keyed scoreboard, and directed frame scenarios.
module tb_julia_frame_scheduler;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int MW = 16;
  localparam int CW = 11;
  localparam int RW = 2*CW + MW;
  localparam logic [31:0] ONE   = 32'h0100_0000;
  localparam logic [31:0] THREE = 32'h0300_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_start = 1'b0;
  logic [CW-1:0]   width = '0, height = '0;
  logic [DW-1:0]   x0 = '0, y0 = '0, dx = '0, dy = '0, cx = '0, cy = '0;
  logic [MW-1:0]   max_iter = '0;
  logic            busy, frame_done, pix_valid;
  logic            pix_ready = 1'b1;
  logic [N-1:0]    core_start, core_done;
  logic [DW-1:0]   core_zx, core_zy, core_cx, core_cy;
  logic [MW-1:0]   core_max_iter, pix_iter;
  logic [N*MW-1:0] core_iter;
  logic [CW-1:0]   pix_x, pix_y;
  logic [1:0]      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_starts = 0;
  int restart_err = 0;
  int stab_err = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  julia_frame_scheduler #(.N_CORES(N), .INTEGER_BITS(8), .FRACTIONAL_BITS(24),
                          .DATA_WIDTH(DW), .MAX_ITER_WIDTH(MW), .COORD_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start),
    .width_i(width), .height_i(height), .x0_i(x0), .y0_i(y0), .dx_i(dx), .dy_i(dy),
    .cx_i(cx), .cy_i(cy), .max_iter_i(max_iter),
    .busy_o(busy), .frame_done_o(frame_done), .core_start_o(core_start),
    .core_zx_o(core_zx), .core_zy_o(core_zy), .core_cx_o(core_cx), .core_cy_o(core_cy),
    .core_max_iter_o(core_max_iter), .core_done_i(core_done), .core_iter_i(core_iter),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_x_o(pix_x), .pix_y_o(pix_y),
    .pix_iter_o(pix_iter), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // behavioural escape-time core: count z -> z^2 + c steps while |z|^2 <= 4
  function automatic int julia_iter(input logic [31:0] zx, zy, ccx, ccy, input logic [15:0] mi);
    real x, y, nx, rcx, rcy;
    int  n;
    x   = $itor($signed(zx)) / 16777216.0;
    y   = $itor($signed(zy)) / 16777216.0;
    rcx = $itor($signed(ccx)) / 16777216.0;
    rcy = $itor($signed(ccy)) / 16777216.0;
    n   = 0;
    while (n < int'(mi) && (x*x + y*y) <= 4.0) begin
      nx = x*x - y*y + rcx;
      y  = 2.0*x*y + rcy;
      x  = nx;
      n++;
    end
    return n;
  endfunction

  logic [N-1:0] m_busy, m_done;
  logic [MW-1:0] m_iter [N];
  int m_cnt [N];
  int m_res [N];
  assign core_done = m_done;
  always_comb begin
    core_iter = '0;
    for (int k = 0; k < N; k++) core_iter[k*MW +: MW] = m_iter[k];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_iter[k] <= '0;
        m_cnt[k]  <= 0;
        m_res[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (core_start[k]) begin
          m_busy[k] <= 1'b1;
          m_done[k] <= 1'b0;
          m_res[k]  <= julia_iter(core_zx, core_zy, core_cx, core_cy, core_max_iter);
          m_cnt[k]  <= 1 + k + julia_iter(core_zx, core_zy, core_cx, core_cy, core_max_iter);
        end else if (m_busy[k]) begin
          if (m_cnt[k] == 0) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_iter[k] <= MW'(m_res[k]);
          end else begin
            m_cnt[k] <= m_cnt[k] - 1;
          end
        end
      end
    end
  end

  // output monitor: accepted results, held-output stability, start pulses, done pulses
  logic          hold_prev = 1'b0;
  logic [RW-1:0] snap;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!pix_valid || {pix_x, pix_y, pix_iter} != snap)) stab_err++;
      if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y, pix_iter});
      hold_prev = pix_valid && !pix_ready;
      snap      = {pix_x, pix_y, pix_iter};
      if (frame_done) n_done++;
      for (int k = 0; k < N; k++) begin
        if (core_start[k]) begin
          n_starts++;
          if (m_busy[k]) restart_err++;
        end
      end
    end
  end

  // driver tasks
  task automatic start_frame(input logic [CW-1:0] w, h, input logic [31:0] ax0, ay0, adx, ady,
                             acx, acy, input logic [MW-1:0] mi);
    @(posedge clk); #1;
    width = w; height = h; x0 = ax0; y0 = ay0; dx = adx; dy = ady;
    cx = acx; cy = acy; max_iter = mi; frame_start = 1'b1;
    got_q.delete();
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int base, input int budget, output bit timed_out);
    int cyc;
    cyc = 0;
    while (n_done == base && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = (n_done == base);
    repeat (4) @(negedge clk);
  endtask

  // scoreboard: match each accepted result to an expected entry by coordinates
  task automatic score(output int bad);
    int idx;
    bad = 0;
    foreach (got_q[g]) begin
      idx = -1;
      foreach (exp_q[e]) if (idx < 0 && exp_q[e][RW-1:MW] == got_q[g][RW-1:MW]) idx = e;
      if (idx < 0) begin
        bad++;
      end else begin
        if (exp_q[idx][MW-1:0] != got_q[g][MW-1:0]) bad++;
        exp_q.delete(idx);
      end
    end
    bad += exp_q.size();
    exp_q.delete();
  endtask

  // 3x3 raster at z = x + i*y, c = 0, max_iter = 5, counts worked by hand
  task automatic load_grid_expect();
    int tbl[9];
    tbl = '{5, 5, 1, 5, 2, 0, 1, 0, 0};
    exp_q.delete();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        exp_q.push_back({CW'(x), CW'(y), MW'(tbl[y*3 + x])});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_vec++; if (core_start !== '0) begin n_err++; $display("FAIL reset_start: got %b expected 0", core_start); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    n_vec++; if (core_max_iter !== '0) begin n_err++; $display("FAIL reset_maxiter: got %0d expected 0", core_max_iter); end
  endtask

  task automatic test_row_maxiter0();
    int base, bad, ngot;
    bit to;
    exp_q.delete();
    for (int x = 0; x < 4; x++) exp_q.push_back({CW'(x), CW'(0), MW'(0)});
    base = n_done;
    start_frame(4, 1, 0, 0, ONE, 0, 0, 0, 0);
    wait_frame(base, 500, to);
    ngot = got_q.size();
    score(bad);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL row_timeout: got %0d expected 0", to); end
    n_vec++; if (ngot !== 4) begin n_err++; $display("FAIL row_count: got %0d expected 4", ngot); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL row_results: got %0d bad expected 0", bad); end
    n_vec++; if (n_done - base !== 1) begin n_err++; $display("FAIL row_done_pulses: got %0d expected 1", n_done - base); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL row_idle: got %b expected 0", busy); end
  endtask

  task automatic test_escape();
    int base, bad, ngot;
    bit to;
    exp_q.delete();
    for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) exp_q.push_back({CW'(x), CW'(y), MW'(0)});
    base = n_done;
    start_frame(2, 2, THREE, 0, 0, 0, 0, 0, 10);
    wait_frame(base, 500, to);
    ngot = got_q.size();
    score(bad);
    n_vec++; if (to !== 1'b0 || ngot !== 4) begin n_err++; $display("FAIL escape_count: got %0d expected 4", ngot); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL escape_results: got %0d bad expected 0", bad); end
    exp_q.delete();
    for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) exp_q.push_back({CW'(x), CW'(y), MW'(10)});
    base = n_done;
    start_frame(2, 2, 0, 0, 0, 0, 0, 0, 10);
    wait_frame(base, 500, to);
    ngot = got_q.size();
    score(bad);
    n_vec++; if (to !== 1'b0 || ngot !== 4) begin n_err++; $display("FAIL bounded_count: got %0d expected 4", ngot); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL bounded_results: got %0d bad expected 0", bad); end
  endtask

  task automatic test_backpressure();
    int base, bad, ngot, cyc, s_mid;
    bit to;
    load_grid_expect();
    stab_err = 0;
    base = n_done;
    start_frame(3, 3, 0, 0, ONE, ONE, 0, 0, 5);
    cyc = 0;
    while (!pix_valid && cyc < 200) begin @(negedge clk); cyc++; end
    n_vec++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b expected 1", pix_valid); end
    @(posedge clk); #1 pix_ready = 1'b0;
    repeat (20) @(negedge clk);
    s_mid = n_starts;
    repeat (30) @(negedge clk);
    n_vec++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %b expected 1", pix_valid); end
    n_vec++; if (n_starts !== s_mid) begin n_err++; $display("FAIL bp_no_restart: got %0d starts expected %0d", n_starts, s_mid); end
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_frame(base, 1000, to);
    ngot = got_q.size();
    score(bad);
    n_vec++; if (stab_err !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
    n_vec++; if (to !== 1'b0 || ngot !== 9) begin n_err++; $display("FAIL bp_count: got %0d expected 9", ngot); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL bp_results: got %0d bad expected 0", bad); end
    n_vec++; if (restart_err !== 0) begin n_err++; $display("FAIL bp_busy_restart: got %0d expected 0", restart_err); end
  endtask

  task automatic test_zero_size();
    int s0, cyc;
    bit seen;
    s0 = n_starts;
    start_frame(0, 3, 0, 0, ONE, ONE, 0, 0, 5);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 10) begin @(negedge clk); cyc++; seen = frame_done; end
    n_vec++; if (cyc - 1 !== 2) begin n_err++; $display("FAIL zero_done_latency: got %0d expected 2", cyc - 1); end
    repeat (3) @(negedge clk);
    n_vec++; if (n_starts !== s0) begin n_err++; $display("FAIL zero_no_start: got %0d expected %0d", n_starts, s0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_idle: got %b expected 0", busy); end
  endtask

  task automatic test_restart_ignored();
    int base, bad, ngot;
    bit to;
    exp_q.delete();
    for (int x = 0; x < 4; x++) exp_q.push_back({CW'(x), CW'(0), MW'(6)});
    base = n_done;
    start_frame(4, 1, 0, 0, 0, 0, 0, 0, 6);
    @(posedge clk); #1;
    x0 = THREE; max_iter = 1; frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    n_vec++; if (core_max_iter !== 16'd6) begin n_err++; $display("FAIL ignore_maxiter: got %0d expected 6", core_max_iter); end
    wait_frame(base, 500, to);
    ngot = got_q.size();
    score(bad);
    n_vec++; if (to !== 1'b0 || ngot !== 4) begin n_err++; $display("FAIL ignore_count: got %0d expected 4", ngot); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL ignore_results: got %0d bad expected 0", bad); end
    n_vec++; if (n_done - base !== 1) begin n_err++; $display("FAIL ignore_done_pulses: got %0d expected 1", n_done - base); end
  endtask

  task automatic test_mid_reset();
    int base, bad, ngot;
    bit to;
    start_frame(3, 3, 0, 0, ONE, ONE, 32'h0010_0000, 0, 5);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL abort_state: got busy=%b state=%0d expected 0", busy, dbg_state); end
    n_vec++; if (core_start !== '0 || core_zx !== '0 || core_zy !== '0) begin n_err++; $display("FAIL abort_core_bus: got start=%b zx=%h expected 0", core_start, core_zx); end
    n_vec++; if (core_cx !== '0 || core_max_iter !== '0) begin n_err++; $display("FAIL abort_config: got cx=%h maxiter=%0d expected 0", core_cx, core_max_iter); end
    n_vec++; if (pix_valid !== 1'b0 || pix_iter !== '0 || frame_done !== 1'b0) begin n_err++; $display("FAIL abort_pix: got valid=%b iter=%0d expected 0", pix_valid, pix_iter); end
    @(posedge clk); #1 rst_n = 1'b1;
    load_grid_expect();
    base = n_done;
    start_frame(3, 3, 0, 0, ONE, ONE, 0, 0, 5);
    wait_frame(base, 1000, to);
    ngot = got_q.size();
    score(bad);
    n_vec++; if (to !== 1'b0 || ngot !== 9) begin n_err++; $display("FAIL after_reset_count: got %0d expected 9", ngot); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL after_reset_results: got %0d bad expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_row_maxiter0();
    test_escape();
    test_backpressure();
    test_zero_size();
    test_restart_ignored();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
